serial_frame_counter: RTL and testbench

Two-level programmable counter for the serial protocol path. It counts bits within a word and words within a frame. It generalises the fixed-terminal bit counter with:
- parametrised widths
- runtime terminal values, latched at frame start
- a start/abort handshake
- selectable stall behaviour
- optional auto-restart

It sits between the serial shift logic and the frame controller and supplies bit/word/frame boundary strobes.

---
 rtl/serial_frame_counter.sv | 91 +++++++++
 tb/tb_serial_frame_counter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_counter.sv
// serial_frame_counter: two-level bit/word counter with latched runtime terminals and boundary strobes
module serial_frame_counter #(
  parameter int BIT_W         = 3,
  parameter int WORD_W        = 4,
  parameter int HOLD_ON_STALL = 0,
  parameter int AUTO_RESTART  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              ena,
  input  logic [BIT_W-1:0]  bit_end,
  input  logic [WORD_W-1:0] word_end,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic [WORD_W-1:0] word_cnt,
  output logic              busy,
  output logic              last_bit,
  output logic              last_word,
  output logic              word_tick,
  output logic              frame_done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [BIT_W-1:0] bit_n, bit_end_q, bit_end_n;
  logic [WORD_W-1:0] word_n, word_end_q, word_end_n;
  logic tick_n, done_n, bit_wrap, word_wrap;
  assign bit_wrap = bit_cnt == bit_end_q;
  assign word_wrap = word_cnt == word_end_q;
  assign busy = state == RUN;
  assign last_bit = busy & bit_wrap;
  assign last_word = busy & word_wrap;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      word_cnt <= '0;
      bit_end_q <= '0;
      word_end_q <= '0;
      word_tick <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_n;
      word_cnt <= word_n;
      bit_end_q <= bit_end_n;
      word_end_q <= word_end_n;
      word_tick <= tick_n;
      frame_done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    bit_n = bit_cnt;
    word_n = word_cnt;
    bit_end_n = bit_end_q;
    word_end_n = word_end_q;
    tick_n = 1'b0;
    done_n = 1'b0;
    if (state == IDLE) begin
      bit_n = '0;
      word_n = '0;
      if (start) begin
        state_n = RUN;
        bit_end_n = bit_end;
        word_end_n = word_end;
      end
    end else if (abort) begin
      state_n = IDLE;
      bit_n = '0;
      word_n = '0;
    end else if (ena) begin
      bit_n = bit_wrap ? '0 : bit_cnt + 1'b1;
      tick_n = bit_wrap;
      if (bit_wrap) begin
        word_n = word_wrap ? '0 : word_cnt + 1'b1;
        done_n = word_wrap;
      end
      if (bit_wrap && word_wrap) begin
        if (AUTO_RESTART != 0) begin
          bit_end_n = bit_end;
          word_end_n = word_end;
        end else begin
          state_n = IDLE;
        end
      end
    end else begin
      bit_n = (HOLD_ON_STALL != 0) ? bit_cnt : '0;
    end
  end
endmodule

// File: tb/tb_serial_frame_counter.sv
// tb_serial_frame_counter: three configurations (default, hold-on-stall, auto-restart) on shared stimulus
module tb_serial_frame_counter;
  logic clk, rst, start, abort, ena;
  logic [2:0] bit_end;
  logic [3:0] word_end;
  logic [2:0] bc [3];
  logic [3:0] wc [3];
  logic bz [3], lb [3], lw [3], wt [3], fd [3];
  int checks = 0, fails = 0;
  int m_pos [3], m_be [3], m_we [3];
  bit m_run [3], m_wt [3], m_fd [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_frame_counter #(.BIT_W(3), .WORD_W(4), .HOLD_ON_STALL(g == 1), .AUTO_RESTART(g == 2)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ena(ena),
      .bit_end(bit_end), .word_end(word_end),
      .bit_cnt(bc[g]), .word_cnt(wc[g]), .busy(bz[g]), .last_bit(lb[g]),
      .last_word(lw[g]), .word_tick(wt[g]), .frame_done(fd[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference: a frame is a linear run of (be+1)*(we+1) bits; counters are derived from the position.
  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pos[k] = 0; m_be[k] = 0; m_we[k] = 0;
      m_run[k] = 0; m_wt[k] = 0; m_fd[k] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 3; k++) begin
      m_wt[k] = 0;
      m_fd[k] = 0;
      if (!m_run[k]) begin
        if (start) begin
          m_run[k] = 1; m_pos[k] = 0; m_be[k] = bit_end; m_we[k] = word_end;
        end
      end else if (abort) begin
        m_run[k] = 0; m_pos[k] = 0;
      end else if (ena) begin
        m_pos[k]++;
        if (m_pos[k] % (m_be[k] + 1) == 0) m_wt[k] = 1;
        if (m_pos[k] == (m_be[k] + 1) * (m_we[k] + 1)) begin
          m_fd[k] = 1;
          m_pos[k] = 0;
          if (k == 2) begin
            m_be[k] = bit_end; m_we[k] = word_end;
          end else begin
            m_run[k] = 0;
          end
        end
      end else if (k != 1) begin
        m_pos[k] -= m_pos[k] % (m_be[k] + 1);
      end
    end
  endfunction

  task automatic cyc(input logic s, input logic a, input logic e);
    start = s; abort = a; ena = e;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    start = 0; abort = 0; ena = 0; rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    bit_end = 3'd5; word_end = 4'd2;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bc[k], wc[k], bz[k], lb[k], lw[k], wt[k], fd[k]} !== 12'h000) begin
        fails++;
        $display("FAIL reset dut%0d got bc=%0d wc=%0d busy=%b lb=%b lw=%b wt=%b fd=%b want all 0",
                 k, bc[k], wc[k], bz[k], lb[k], lw[k], wt[k], fd[k]);
      end
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    bit_end = 3'd6; word_end = 4'd1;
    cyc(1, 0, 0);
    checks++;
    if ({bz[0], bc[0]} !== 4'b1_000) begin
      fails++; $display("FAIL start_busy got busy=%b bc=%0d want busy=1 bc=0", bz[0], bc[0]);
    end
    for (int i = 1; i <= 14; i++) begin
      cyc(0, 0, 1);
      checks++;
      if ({wt[0], fd[0], bz[0], bc[0], wc[0]} !== {i == 7 || i == 14, i == 14, i != 14, 3'(i % 7), 4'(i >= 7 && i < 14)}) begin
        fails++;
        $display("FAIL full_frame ena=%0d got wt=%b fd=%b busy=%b bc=%0d wc=%0d want wt=%b fd=%b busy=%b bc=%0d wc=%0d",
                 i, wt[0], fd[0], bz[0], bc[0], wc[0], i == 7 || i == 14, i == 14, i != 14, i % 7, i >= 7 && i < 14);
      end
    end
    cyc(0, 0, 0);
    checks++;
    if ({wt[0], fd[0], bz[0]} !== 3'b000) begin
      fails++; $display("FAIL pulse_width got wt=%b fd=%b busy=%b want 0 0 0", wt[0], fd[0], bz[0]);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bit_end = 3'd6; word_end = 4'd1;
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 1);
    checks++;
    if ({bc[0], bc[1]} !== {3'd4, 3'd4}) begin
      fails++; $display("FAIL stall_pre got bc0=%0d bc1=%0d want 4 4", bc[0], bc[1]);
    end
    cyc(0, 0, 0);
    checks++;
    if ({bc[0], wc[0], bc[1], bz[0], bz[1]} !== {3'd0, 4'd0, 3'd4, 2'b11}) begin
      fails++; $display("FAIL stall got bc0=%0d wc0=%0d bc1=%0d busy=%b%b want 0 0 4 11", bc[0], wc[0], bc[1], bz[0], bz[1]);
    end
    cyc(0, 0, 1);
    checks++;
    if ({bc[0], bc[1]} !== {3'd1, 3'd5}) begin
      fails++; $display("FAIL stall_resume got bc0=%0d bc1=%0d want 1 5", bc[0], bc[1]);
    end
    cyc(0, 1, 0);
  endtask

  task automatic test_zero_terminal();
    do_reset();
    bit_end = 3'd0; word_end = 4'd0;
    cyc(1, 0, 0);
    checks++;
    if ({bz[0], lb[0], lw[0]} !== 3'b111) begin
      fails++; $display("FAIL zero_last got busy=%b lb=%b lw=%b want 111", bz[0], lb[0], lw[0]);
    end
    cyc(0, 0, 1);
    checks++;
    if ({wt[0], fd[0], bz[0], bz[2], lb[0], lw[0]} !== 6'b110100) begin
      fails++; $display("FAIL zero_done got wt=%b fd=%b busy0=%b busy2=%b lb=%b lw=%b want 1 1 0 1 0 0",
                        wt[0], fd[0], bz[0], bz[2], lb[0], lw[0]);
    end
    cyc(0, 0, 0);
    checks++;
    if ({wt[0], fd[0]} !== 2'b00) begin
      fails++; $display("FAIL zero_pulse got wt=%b fd=%b want 0 0", wt[0], fd[0]);
    end
  endtask

  task automatic test_abort();
    do_reset();
    bit_end = 3'd6; word_end = 4'd2;
    cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 1);
    checks++;
    if ({bc[0], wc[0]} !== {3'd3, 4'd1}) begin
      fails++; $display("FAIL abort_pre got bc=%0d wc=%0d want 3 1", bc[0], wc[0]);
    end
    cyc(0, 1, 1);
    checks++;
    if ({bz[0], bc[0], wc[0], wt[0], fd[0]} !== 10'd0) begin
      fails++; $display("FAIL abort got busy=%b bc=%0d wc=%0d wt=%b fd=%b want all 0", bz[0], bc[0], wc[0], wt[0], fd[0]);
    end
    bit_end = 3'd0; word_end = 4'd0;
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    checks++;
    if ({bz[0], wt[0], fd[0]} !== 3'b000) begin
      fails++; $display("FAIL abort_final got busy=%b wt=%b fd=%b want 0 0 0", bz[0], wt[0], fd[0]);
    end
    cyc(1, 1, 0);
    checks++;
    if (bz[0] !== 1'b1) begin
      fails++; $display("FAIL start_vs_abort got busy=%b want 1", bz[0]);
    end
    cyc(0, 1, 0);
  endtask

  task automatic test_auto_restart();
    do_reset();
    bit_end = 3'd2; word_end = 4'd0;
    cyc(1, 0, 0);
    bit_end = 3'd1;
    repeat (2) cyc(0, 0, 1);
    checks++;
    if ({bc[2], fd[2]} !== {3'd2, 1'b0}) begin
      fails++; $display("FAIL auto_first got bc=%0d fd=%b want 2 0", bc[2], fd[2]);
    end
    cyc(0, 0, 1);
    checks++;
    if ({fd[2], bz[2], bc[2]} !== {2'b11, 3'd0}) begin
      fails++; $display("FAIL auto_done got fd=%b busy=%b bc=%0d want 1 1 0", fd[2], bz[2], bc[2]);
    end
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    checks++;
    if ({fd[2], wt[2], bz[2]} !== 3'b111) begin
      fails++; $display("FAIL auto_second got fd=%b wt=%b busy=%b want 1 1 1", fd[2], wt[2], bz[2]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bit_end = 3'd6; word_end = 4'd1;
    cyc(1, 0, 0);
    repeat (5) cyc(0, 0, 1);
    checks++;
    if (bc[0] !== 3'd5) begin
      fails++; $display("FAIL arst_pre got bc=%0d want 5", bc[0]);
    end
    #2 rst = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bc[k], wc[k], bz[k], lb[k], lw[k], wt[k], fd[k]} !== 12'h000) begin
        fails++; $display("FAIL arst dut%0d got bc=%0d wc=%0d busy=%b lb=%b lw=%b want all 0", k, bc[k], wc[k], bz[k], lb[k], lw[k]);
      end
    end
    start = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bz[0] !== 1'b0) begin
      fails++; $display("FAIL arst_start got busy=%b want 0", bz[0]);
    end
    rst = 0; start = 0;
    model_reset();
    bit_end = 3'd0;
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    checks++;
    if ({fd[0], bz[0]} !== 2'b10) begin
      fails++; $display("FAIL arst_after got fd=%b busy=%b want 1 0", fd[0], bz[0]);
    end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        bit_end = 3'($urandom_range(0, 7));
        word_end = 4'($urandom_range(0, 3));
      end
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, $urandom_range(0, 4) != 0);
      for (int k = 0; k < 3; k++) begin
        exp = {3'(m_pos[k] % (m_be[k] + 1)), 4'(m_pos[k] / (m_be[k] + 1)), m_run[k],
               m_run[k] && (m_pos[k] % (m_be[k] + 1) == m_be[k]),
               m_run[k] && (m_pos[k] / (m_be[k] + 1) == m_we[k]), m_wt[k], m_fd[k]};
        checks++;
        if ({bc[k], wc[k], bz[k], lb[k], lw[k], wt[k], fd[k]} !== exp) begin
          fails++;
          $display("FAIL random cyc=%0d dut%0d got {bc,wc,busy,lb,lw,wt,fd}=%h want %h",
                   n, k, {bc[k], wc[k], bz[k], lb[k], lw[k], wt[k], fd[k]}, exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; ena = 0; bit_end = 0; word_end = 0;
    model_reset();
    test_reset();
    test_full_frame();
    test_stall();
    test_zero_terminal();
    test_abort();
    test_auto_restart();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end
endmodule
